// File: rtl/axi_arbiter_w.sv
// rtl/axi_arbiter_w.sv - round-robin write-path arbiter for four AXI masters with stall watchdog
module axi_arbiter_w #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic m0_AWVALID,
  input  logic m1_AWVALID,
  input  logic m2_AWVALID,
  input  logic m3_AWVALID,
  input  logic s_AWVALID,
  input  logic s_WVALID,
  input  logic s_WLAST,
  input  logic s_BREADY,
  input  logic m_AWREADY,
  input  logic m_WREADY,
  input  logic m_BVALID,
  output logic m0_wgrnt,
  output logic m1_wgrnt,
  output logic m2_wgrnt,
  output logic m3_wgrnt,
  output logic w_busy,
  output logic wdog_err
);
  localparam bit WDOG_EN = (WDOG_CYCLES > 0);
  localparam int CW = WDOG_EN ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_EN ? WDOG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_grant;
  logic [1:0]    r_last;
  logic          r_aw_done;
  logic          r_w_done;
  logic          r_busy;
  logic          r_wdog_err;
  logic [CW-1:0] r_cnt;

  logic [3:0] w_req;
  logic [1:0] w_win_idx;
  logic       w_found;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_w_last_hs;
  logic       w_b_hs;
  logic       w_progress;
  logic       w_xfer_done;
  logic       w_wdog_hit;

  assign w_req       = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
  assign w_aw_hs     = s_AWVALID & m_AWREADY;
  assign w_w_hs      = s_WVALID & m_WREADY;
  assign w_w_last_hs = w_w_hs & s_WLAST;
  assign w_b_hs      = m_BVALID & s_BREADY;
  assign w_progress  = w_aw_hs | w_w_hs | w_b_hs;
  assign w_xfer_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_last_hs);
  // The increment that would reach WDOG_CYCLES releases the grant instead.
  assign w_wdog_hit  = WDOG_EN && !w_progress && (r_cnt == WDOG_LAST);

  always_comb begin
    w_win_idx = r_last;
    w_found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && w_req[r_last + 2'(i)]) begin
        w_win_idx = r_last + 2'(i);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_grant    <= 4'b0000;
      r_last     <= 2'd3;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_busy     <= 1'b0;
      r_wdog_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_wdog_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant   <= 4'b0001 << w_win_idx;
            r_busy    <= 1'b1;
            r_last    <= w_win_idx;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= '0;
            r_state   <= XFER;
          end
        end
        XFER, RESP: begin
          if (w_aw_hs)     r_aw_done <= 1'b1;
          if (w_w_last_hs) r_w_done  <= 1'b1;
          r_cnt <= w_progress ? '0 : r_cnt + CW'(1);
          // A response that lands in the same cycle as AW/W completion closes the transaction at once.
          if ((r_state == RESP || w_xfer_done) && w_b_hs) begin
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_state == XFER && w_xfer_done) begin
            r_state <= RESP;
          end else if (w_wdog_hit) begin
            r_grant    <= 4'b0000;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_wdog_err <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_wgrnt = r_grant[0];
  assign m1_wgrnt = r_grant[1];
  assign m2_wgrnt = r_grant[2];
  assign m3_wgrnt = r_grant[3];
  assign w_busy   = r_busy;
  assign wdog_err = r_wdog_err;

endmodule
